button_events: RTL

Input-side front end for the board's push buttons: the counterpart to the display drivers, which only send outputs to the user. Takes raw, asynchronous, mixed-polarity button pins and turns each one into a clean debounced level plus single-cycle press, release and long-press event pulses. Timing, control and lap logic consume these pulses instead of sampling pins directly. One instance serves all buttons on the board.

---
 rtl/button_events.sv | 102 ++++++++++
 1 files changed

// File: rtl/button_events.sv
// button_events: raw push-button pins to debounced levels and
// single-cycle press, release and long-press pulses.
module button_events #(
   parameter int                 NUM_BTN         = 4,
   parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = NUM_BTN'(4'b0001),
   parameter int                 DEBOUNCE_CYCLES = 120000,
   parameter int                 LONG_CYCLES     = 12000000
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_long
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;
   logic [NUM_BTN-1:0] w_norm;

   // two-flop synchronizer; reset loads the idle pin level
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_sync1 <= ACTIVE_LOW_MASK;
         r_sync2 <= ACTIVE_LOW_MASK;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // 1 = pressed regardless of pin polarity
   assign w_norm = r_sync2 ^ ACTIVE_LOW_MASK;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      logic [DW-1:0] r_db_cnt;
      logic [HW-1:0] r_hold_cnt;
      logic          r_level;
      logic          r_press;
      logic          r_release;
      logic          r_fired;
      logic          r_long;

      // accept a new level after an unbroken run of mismatching samples
      always_ff @(posedge CLK) begin
         if (!RST_N) begin
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_norm[g] == r_level) begin
               r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
               r_db_cnt  <= '0;
               r_level   <= w_norm[g];
               r_press   <= w_norm[g];
               r_release <= ~w_norm[g];
            end else begin
               r_db_cnt <= r_db_cnt + 1'b1;
            end
         end
      end

      // count held cycles and fire one long pulse per press
      always_ff @(posedge CLK) begin
         if (!RST_N) begin
            r_hold_cnt <= '0;
            r_fired    <= 1'b0;
            r_long     <= 1'b0;
         end else begin
            r_long <= 1'b0;
            if (!r_level) begin
               r_hold_cnt <= '0;
               r_fired    <= 1'b0;
            end else if (!r_fired) begin
               if (r_hold_cnt == HOLD_LAST) begin
                  r_long  <= 1'b1;
                  r_fired <= 1'b1;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
         end
      end

      assign btn_level[g]   = r_level;
      assign btn_press[g]   = r_press;
      assign btn_release[g] = r_release;
      assign btn_long[g]    = r_long;
   end

endmodule
